// File: rtl/reg_file_param_pkg.sv
// rtl/reg_file_param_pkg.sv - shared types and defaults for the parametrised register file
package regfile_pkg;

    // Sweep-clear engine states
    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SWEEP = 1'b1
    } clr_state_e;

    // Default geometry of the register file
    localparam int DEF_DATA_W = 8;
    localparam int DEF_DEPTH  = 8;

    // True when an address selects the hardwired zero entry
    function automatic logic is_zero_hit(input int zero_reg, input logic [31:0] addr);
        return (zero_reg != 0) && (addr == 32'd0);
    endfunction

endpackage

// File: rtl/reg_file_param_if.sv
// rtl/reg_file_param_if.sv - write/read/clear bus of the register file
interface reg_file_param_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
);
    logic              WRITE;
    logic [ADDR_W-1:0] INADDR;
    logic [DATA_W-1:0] IN;
    logic [ADDR_W-1:0] OUT1ADDR;
    logic [ADDR_W-1:0] OUT2ADDR;
    logic [DATA_W-1:0] OUT1;
    logic [DATA_W-1:0] OUT2;
    logic              CLEAR;
    logic              BUSY;
    logic              WR_DROP;

    // Datapath side: drives writes, read addresses and clear requests
    modport master (
        output WRITE, INADDR, IN, OUT1ADDR, OUT2ADDR, CLEAR,
        input  OUT1, OUT2, BUSY, WR_DROP
    );

    // Register file side
    modport slave (
        input  WRITE, INADDR, IN, OUT1ADDR, OUT2ADDR, CLEAR,
        output OUT1, OUT2, BUSY, WR_DROP
    );
endinterface

// File: rtl/reg_file_param_clear_fsm.sv
// rtl/reg_file_param_clear_fsm.sv - sweep-clear engine: walks every entry once, one per cycle
module reg_file_clear_fsm
    import regfile_pkg::*;
#(
    parameter int DEPTH  = DEF_DEPTH,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              clear_i,
    output logic              busy_o,
    output logic              clr_en_o,
    output logic [ADDR_W-1:0] clr_addr_o
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    clr_state_e        state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;

    // State and sweep pointer registers
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    // Next state: a clear request only starts a sweep from IDLE, so re-requests are ignored
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            ST_IDLE: begin
                if (clear_i) begin
                    state_d = ST_SWEEP;
                    ptr_d   = '0;
                end
            end
            ST_SWEEP: begin
                if (ptr_q == LAST_ADDR) begin
                    state_d = ST_IDLE;
                    ptr_d   = '0;
                end else begin
                    ptr_d = ptr_q + ADDR_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                ptr_d   = '0;
            end
        endcase
    end

    // Outputs: every SWEEP cycle clears the entry under the pointer
    always_comb begin
        busy_o     = (state_q == ST_SWEEP);
        clr_en_o   = (state_q == ST_SWEEP);
        clr_addr_o = ptr_q;
    end

endmodule

// File: rtl/reg_file_param.sv
// rtl/reg_file_param.sv - two-read-port register file with zero register, bypass and sweep clear
module reg_file_param
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int ADDR_W   = $clog2(DEPTH),
    parameter int ZERO_REG = 0,
    parameter int BYPASS   = 1
) (
    input  logic            CLK,
    input  logic            RESET,
    reg_file_param_if.slave bus
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              wr_drop_q, wr_drop_d;
    logic              busy;
    logic              clr_en;
    logic [ADDR_W-1:0] clr_addr;
    logic              zero_hit;
    logic              wr_ok;
    logic [DATA_W-1:0] out1_d, out2_d;

    reg_file_clear_fsm #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_clear_fsm (
        .CLK        (CLK),
        .RESET      (RESET),
        .clear_i    (bus.CLEAR),
        .busy_o     (busy),
        .clr_en_o   (clr_en),
        .clr_addr_o (clr_addr)
    );

    // Write qualification: a busy sweep or the hardwired zero entry swallows the write
    always_comb begin
        zero_hit  = is_zero_hit(ZERO_REG, 32'(bus.INADDR));
        wr_ok     = bus.WRITE && !busy && !zero_hit;
        wr_drop_d = bus.WRITE && !wr_ok;
    end

    // Storage array; reset beats the sweep, which beats a normal write
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (clr_en) begin
            mem_q[clr_addr] <= '0;
        end else if (wr_ok) begin
            mem_q[bus.INADDR] <= bus.IN;
        end
    end

    // Dropped-write flag, high for exactly the cycle after the discarded write
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            wr_drop_q <= 1'b0;
        end else begin
            wr_drop_q <= wr_drop_d;
        end
    end

    // Read port 1: zero entry, then bypass of an accepted write, then stored contents
    always_comb begin
        out1_d = mem_q[bus.OUT1ADDR];
        if (is_zero_hit(ZERO_REG, 32'(bus.OUT1ADDR))) begin
            out1_d = '0;
        end else if ((BYPASS != 0) && wr_ok && (bus.OUT1ADDR == bus.INADDR)) begin
            out1_d = bus.IN;
        end
    end

    // Read port 2: same priority as port 1, evaluated independently
    always_comb begin
        out2_d = mem_q[bus.OUT2ADDR];
        if (is_zero_hit(ZERO_REG, 32'(bus.OUT2ADDR))) begin
            out2_d = '0;
        end else if ((BYPASS != 0) && wr_ok && (bus.OUT2ADDR == bus.INADDR)) begin
            out2_d = bus.IN;
        end
    end

    // Drive the bus outputs
    always_comb begin
        bus.OUT1    = out1_d;
        bus.OUT2    = out2_d;
        bus.BUSY    = busy;
        bus.WR_DROP = wr_drop_q;
    end

endmodule

// File: tb/tb_reg_file_param.sv
// tb/tb_reg_file_param.sv - directed checks of two register file configurations
`timescale 1ns/1ps
module tb_reg_file_param;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_fail;

    reg_file_param_if #(.DATA_W(8), .ADDR_W(3)) ifa ();
    reg_file_param_if #(.DATA_W(8), .ADDR_W(3)) ifb ();

    // A: no zero register, bypass on.  B: zero register, bypass off.
    reg_file_param #(.DATA_W(8), .DEPTH(8), .ZERO_REG(0), .BYPASS(1)) dut_a (
        .CLK   (clk),
        .RESET (rst_n),
        .bus   (ifa)
    );
    reg_file_param #(.DATA_W(8), .DEPTH(8), .ZERO_REG(1), .BYPASS(0)) dut_b (
        .CLK   (clk),
        .RESET (rst_n),
        .bus   (ifb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       w;
        logic [2:0] ia;
        logic [7:0] d;
        logic [2:0] r1;
        logic [2:0] r2;
        logic [7:0] a1;
        logic [7:0] a2;
        logic [7:0] b1;
        logic [7:0] b2;
        logic       da;
        logic       db;
    } vec_t;

    vec_t tv [8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic w, input logic [2:0] ia, input logic [7:0] d,
                         input logic [2:0] r1, input logic [2:0] r2, input logic clr);
        ifa.WRITE = w;  ifa.INADDR = ia; ifa.IN = d;
        ifa.OUT1ADDR = r1; ifa.OUT2ADDR = r2; ifa.CLEAR = clr;
        ifb.WRITE = w;  ifb.INADDR = ia; ifb.IN = d;
        ifb.OUT1ADDR = r1; ifb.OUT2ADDR = r2; ifb.CLEAR = clr;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] fillv(input int k);
        return 8'(8'h11 * (k + 1));
    endfunction

    task automatic chk_all_zero(input string tag);
        for (int a = 0; a < 8; a++) begin
            drive(1'b0, 3'd0, 8'h00, 3'(a), 3'(7 - a), 1'b0);
            #1;
            chk($sformatf("%s A out1[%0d]", tag, a), 32'(ifa.OUT1), 32'h0);
            chk($sformatf("%s A out2[%0d]", tag, 7 - a), 32'(ifa.OUT2), 32'h0);
            chk($sformatf("%s B out1[%0d]", tag, a), 32'(ifb.OUT1), 32'h0);
            chk($sformatf("%s B out2[%0d]", tag, 7 - a), 32'(ifb.OUT2), 32'h0);
        end
    endtask

    initial begin
        int n_busy;
        n_chk  = 0;
        n_fail = 0;

        // {w, ia, d, r1, r2, A out1, A out2, B out1, B out2, A drop, B drop}
        tv[0] = '{1'b1, 3'd3, 8'hA5, 3'd3, 3'd3, 8'hA5, 8'hA5, 8'h00, 8'h00, 1'b0, 1'b0};
        tv[1] = '{1'b0, 3'd0, 8'h00, 3'd3, 3'd0, 8'hA5, 8'h00, 8'hA5, 8'h00, 1'b0, 1'b0};
        tv[2] = '{1'b1, 3'd0, 8'hFF, 3'd0, 3'd0, 8'hFF, 8'hFF, 8'h00, 8'h00, 1'b0, 1'b0};
        tv[3] = '{1'b0, 3'd0, 8'h00, 3'd0, 3'd3, 8'hFF, 8'hA5, 8'h00, 8'hA5, 1'b0, 1'b1};
        tv[4] = '{1'b0, 3'd0, 8'h00, 3'd0, 3'd0, 8'hFF, 8'hFF, 8'h00, 8'h00, 1'b0, 1'b0};
        tv[5] = '{1'b1, 3'd5, 8'h3C, 3'd5, 3'd3, 8'h3C, 8'hA5, 8'h00, 8'hA5, 1'b0, 1'b0};
        tv[6] = '{1'b1, 3'd5, 8'hC3, 3'd5, 3'd5, 8'hC3, 8'hC3, 8'h3C, 8'h3C, 1'b0, 1'b0};
        tv[7] = '{1'b0, 3'd0, 8'h00, 3'd5, 3'd0, 8'hC3, 8'hFF, 8'hC3, 8'h00, 1'b0, 1'b0};

        // Reset state
        rst_n = 1'b0;
        drive(1'b0, 3'd0, 8'h00, 3'd0, 3'd0, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset A busy", 32'(ifa.BUSY), 32'h0);
        chk("reset A drop", 32'(ifa.WR_DROP), 32'h0);
        chk("reset B busy", 32'(ifb.BUSY), 32'h0);
        chk("reset A out1", 32'(ifa.OUT1), 32'h0);
        rst_n = 1'b1;
        cyc();

        // Load every entry, then reset asynchronously in mid-cycle
        for (int k = 0; k < 8; k++) begin
            drive(1'b1, 3'(k), 8'hF0 | 8'(k), 3'd0, 3'd0, 1'b0);
            cyc();
        end
        drive(1'b0, 3'd0, 8'h00, 3'd3, 3'd7, 1'b0);
        @(negedge clk);
        chk("loaded A out1[3]", 32'(ifa.OUT1), 32'hF3);
        chk("loaded B out2[7]", 32'(ifb.OUT2), 32'hF7);
        rst_n = 1'b0;
        #1;
        chk("async reset A busy", 32'(ifa.BUSY), 32'h0);
        chk("async reset B drop", 32'(ifb.WR_DROP), 32'h0);
        chk_all_zero("async reset");
        cyc();
        rst_n = 1'b1;

        // Write/read, bypass and zero register vectors
        for (int i = 0; i < 8; i++) begin
            drive(tv[i].w, tv[i].ia, tv[i].d, tv[i].r1, tv[i].r2, 1'b0);
            @(negedge clk);
            chk($sformatf("vec%0d A out1", i), 32'(ifa.OUT1), 32'(tv[i].a1));
            chk($sformatf("vec%0d A out2", i), 32'(ifa.OUT2), 32'(tv[i].a2));
            chk($sformatf("vec%0d B out1", i), 32'(ifb.OUT1), 32'(tv[i].b1));
            chk($sformatf("vec%0d B out2", i), 32'(ifb.OUT2), 32'(tv[i].b2));
            chk($sformatf("vec%0d A drop", i), 32'(ifa.WR_DROP), 32'(tv[i].da));
            chk($sformatf("vec%0d B drop", i), 32'(ifb.WR_DROP), 32'(tv[i].db));
            cyc();
        end

        // Sweep: fill 0x11..0x88, clear, re-pulse CLEAR at cycle 4, write at cycle 2
        for (int k = 0; k < 8; k++) begin
            drive(1'b1, 3'(k), fillv(k), 3'd0, 3'd0, 1'b0);
            cyc();
        end
        drive(1'b0, 3'd0, 8'h00, 3'd0, 3'd0, 1'b1);
        cyc();
        for (int c = 0; c < 8; c++) begin
            drive(c == 2, 3'd7, 8'h5A, 3'(c), (c == 0) ? 3'd7 : 3'(c - 1), c == 4);
            @(negedge clk);
            chk($sformatf("sweep%0d A busy", c), 32'(ifa.BUSY), 32'h1);
            chk($sformatf("sweep%0d B busy", c), 32'(ifb.BUSY), 32'h1);
            chk($sformatf("sweep%0d A out1", c), 32'(ifa.OUT1), 32'(fillv(c)));
            chk($sformatf("sweep%0d B out1", c), 32'(ifb.OUT1), (c == 0) ? 32'h0 : 32'(fillv(c)));
            chk($sformatf("sweep%0d A out2", c), 32'(ifa.OUT2), (c == 0) ? 32'h88 : 32'h0);
            chk($sformatf("sweep%0d B out2", c), 32'(ifb.OUT2), (c == 0) ? 32'h88 : 32'h0);
            chk($sformatf("sweep%0d A drop", c), 32'(ifa.WR_DROP), 32'(c == 3));
            chk($sformatf("sweep%0d B drop", c), 32'(ifb.WR_DROP), 32'(c == 3));
            cyc();
        end
        drive(1'b0, 3'd0, 8'h00, 3'd0, 3'd0, 1'b0);
        @(negedge clk);
        chk("post sweep A busy", 32'(ifa.BUSY), 32'h0);
        chk("post sweep B busy", 32'(ifb.BUSY), 32'h0);
        chk_all_zero("post sweep");
        cyc();

        // Reset mid-sweep, then a fresh sweep that coincides with a write
        drive(1'b1, 3'd5, 8'h55, 3'd0, 3'd0, 1'b0);
        cyc();
        drive(1'b1, 3'd6, 8'h66, 3'd0, 3'd0, 1'b0);
        cyc();
        drive(1'b0, 3'd0, 8'h00, 3'd5, 3'd6, 1'b1);
        cyc();
        drive(1'b0, 3'd0, 8'h00, 3'd5, 3'd6, 1'b0);
        repeat (3) cyc();
        @(negedge clk);
        chk("pre abort A busy", 32'(ifa.BUSY), 32'h1);
        chk("pre abort A out2", 32'(ifa.OUT2), 32'h66);
        rst_n = 1'b0;
        #1;
        chk("abort A busy", 32'(ifa.BUSY), 32'h0);
        chk("abort B busy", 32'(ifb.BUSY), 32'h0);
        chk_all_zero("abort");
        cyc();
        rst_n = 1'b1;

        drive(1'b1, 3'd6, 8'h77, 3'd6, 3'd5, 1'b1);
        @(negedge clk);
        chk("clear+write A bypass", 32'(ifa.OUT1), 32'h77);
        chk("clear+write B no bypass", 32'(ifb.OUT1), 32'h0);
        cyc();
        n_busy = 0;
        for (int i = 0; i < 20; i++) begin
            drive(1'b0, 3'd0, 8'h00, 3'd6, 3'd5, 1'b0);
            @(negedge clk);
            if (!ifa.BUSY) break;
            n_busy++;
            chk($sformatf("fresh sweep%0d B busy", n_busy - 1), 32'(ifb.BUSY), 32'h1);
            if (n_busy == 1) begin
                chk("fresh sweep A out1[6]", 32'(ifa.OUT1), 32'h77);
                chk("fresh sweep B out1[6]", 32'(ifb.OUT1), 32'h77);
            end
            cyc();
        end
        chk("fresh sweep busy cycles", 32'(n_busy), 32'd8);
        chk("fresh sweep end A out1[6]", 32'(ifa.OUT1), 32'h0);
        chk("fresh sweep end B busy", 32'(ifb.BUSY), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
